// File: rtl/ifid_hazard_controller_pkg.sv
// ifid_hazard_controller_pkg: shared state encoding and constants for the IF/ID hazard controller
package ifid_hazard_controller_pkg;
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } hz_state_e;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int MDU_LATENCY_DEF = 32;
endpackage

// File: rtl/ifid_hazard_controller_loaduse.sv
// hazard_loaduse_detect: flags an ID instruction that reads the destination of a load sitting in EX
module hazard_loaduse_detect
    import ifid_hazard_controller_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    output logic             LoadUse
);
    assign LoadUse = IDEX_MemRead && (IDEX_Rt != REG_W'(REG_ZERO)) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
endmodule

// File: rtl/ifid_hazard_controller.sv
// ifid_hazard_controller: PC / IF/ID stall, flush and bubble sequencing with saturating debug statistics
module ifid_hazard_controller
    import ifid_hazard_controller_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = 32,
    parameter int REG_W       = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic             MDU_Start,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFFlush,
    output logic             IDEX_Bubble,
    output logic             MDU_Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

    hz_state_e        state_q, state_d;
    logic [CW-1:0]    mdu_cnt_q, mdu_cnt_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             loaduse;

    hazard_loaduse_detect #(.REG_W(REG_W)) u_detect (
        .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt     (IDEX_Rt),
        .IFID_Rs     (IFID_Rs),
        .IFID_Rt     (IFID_Rt),
        .IFID_UsesRt (IFID_UsesRt),
        .LoadUse     (loaduse)
    );

    // Mealy control outputs and next state; load-use beats flush beats MDU entry
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFFlush     = 1'b0;
        IDEX_Bubble = 1'b0;
        MDU_Busy    = 1'b0;
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;
        rel_d       = 1'b0;
        if (Rst) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFFlush     = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (state_q == ST_MDU_WAIT) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            MDU_Busy    = 1'b1;
            if (mdu_cnt_q != '0) begin
                mdu_cnt_d = mdu_cnt_q - CW'(1);
            end else begin
                state_d = ST_RUN;
                rel_d   = 1'b1;
            end
        end else if (loaduse) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (Branch_Taken || Jump) begin
            IFFlush = 1'b1;
        end else if (MDU_Start && !rel_q) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            mdu_cnt_d   = CW'(MDU_LATENCY - 2);
            state_d     = ST_MDU_WAIT;
        end
    end

    // State, wait counter and one-shot release flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= '0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            rel_q     <= rel_d;
        end
    end

    // Saturating stall and flush statistics
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (IDEX_Bubble && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (IFFlush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_ifid_hazard_controller.sv
// tb_ifid_hazard_controller: directed checks of stall, flush, MDU wait and counter saturation
module tb_ifid_hazard_controller;
    logic       Clk, Rst;
    logic       IDEX_MemRead, IFID_UsesRt, Branch_Taken, Jump, MDU_Start;
    logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
    logic       PCWrite, IFIDWrite, IFFlush, IDEX_Bubble, MDU_Busy;
    logic [31:0] StallCount, FlushCount;
    logic       s_pcw, s_ifw, s_fl, s_bub, s_busy;
    logic [3:0] s_stall, s_flush;
    int total = 0;
    int bad = 0;

    ifid_hazard_controller #(.MDU_LATENCY(32), .CNT_W(32), .REG_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .Branch_Taken(Branch_Taken), .Jump(Jump), .MDU_Start(MDU_Start),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFFlush(IFFlush),
        .IDEX_Bubble(IDEX_Bubble), .MDU_Busy(MDU_Busy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    ifid_hazard_controller #(.MDU_LATENCY(32), .CNT_W(4), .REG_W(5)) dut_small (
        .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .Branch_Taken(Branch_Taken), .Jump(Jump), .MDU_Start(MDU_Start),
        .PCWrite(s_pcw), .IFIDWrite(s_ifw), .IFFlush(s_fl),
        .IDEX_Bubble(s_bub), .MDU_Busy(s_busy),
        .StallCount(s_stall), .FlushCount(s_flush)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic pcw, input logic fl, input logic bub, input logic busy);
        #1;
        check({tag, ".pcw"}, PCWrite, pcw);
        check({tag, ".ifw"}, IFIDWrite, pcw);
        check({tag, ".flush"}, IFFlush, fl);
        check({tag, ".bubble"}, IDEX_Bubble, bub);
        check({tag, ".busy"}, MDU_Busy, busy);
    endtask

    task automatic mdu_sequence(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_ctl($sformatf("%s.c%0d", tag, i), 1'b0, 1'b0, 1'b1, i > 0);
            tick();
        end
        check_ctl({tag, ".release"}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Rst = 1'b1; IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
        IFID_UsesRt = 0; Branch_Taken = 0; Jump = 0; MDU_Start = 0;
        tick();
        check_ctl("reset", 1'b0, 1'b1, 1'b0 | 1'b1, 1'b0);
        tick();
        Rst = 1'b0;
        check_ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle.stall", StallCount, 0);
        check("idle.flushc", FlushCount, 0);
        IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8;
        check_ctl("loaduse", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        IDEX_MemRead = 0;
        check_ctl("after_lu", 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu.stall", StallCount, 1);
        IDEX_MemRead = 1; IDEX_Rt = 0; IFID_Rs = 0;
        check_ctl("zero_reg", 1'b1, 1'b0, 1'b0, 1'b0);
        IDEX_Rt = 9; IFID_Rt = 9; IFID_Rs = 1; IFID_UsesRt = 0;
        check_ctl("rt_unused", 1'b1, 1'b0, 1'b0, 1'b0);
        IFID_UsesRt = 1;
        check_ctl("rt_used", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        IDEX_MemRead = 0; IFID_UsesRt = 0;
        check("rt.stall", StallCount, 2);
        IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8; Branch_Taken = 1;
        check_ctl("br_lu", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        IDEX_MemRead = 0;
        check_ctl("br", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        Branch_Taken = 0;
        check("br.flushc", FlushCount, 1);
        check("br.stall", StallCount, 3);
        Jump = 1;
        check_ctl("jump", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        Jump = 0;
        check("jump.flushc", FlushCount, 2);
        MDU_Start = 1;
        mdu_sequence("mdu");
        check("mdu.stall", StallCount, 35);
        tick();
        MDU_Start = 0;
        check_ctl("mdu.after", 1'b1, 1'b0, 1'b0, 1'b0);
        check("mdu.stall2", StallCount, 35);
        MDU_Start = 1;
        for (int i = 0; i < 6; i++) tick();
        Rst = 1'b1;
        check_ctl("mid_rst", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        Rst = 1'b0;
        check("mid_rst.stall", StallCount, 0);
        check("mid_rst.flushc", FlushCount, 0);
        mdu_sequence("mdu2");
        tick();
        MDU_Start = 0;
        check("mdu2.stall", StallCount, 32);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8;
        for (int i = 0; i < 20; i++) tick();
        check("sat.small", s_stall, 15);
        check("sat.big", StallCount, 20);
        tick();
        check("sat.hold", s_stall, 15);
        check("sat.flush", s_flush, 0);
        IDEX_MemRead = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifid_hazard_controller.md
Name: ifid_hazard_controller

Overview:
- Sequences the IF/ID pipeline buffer and the PC register of the 5-stage MIPS pipeline.
- Generates PC write-enable, IF/ID write-enable, IF/ID flush and ID/EX bubble.
- Covers three cases: load-use hazards, taken branches/jumps resolved in ID, and multi-cycle multiply/divide (MDU) occupancy.
- Keeps saturating stall/flush statistics for debug.

Parameters:
MDU_LATENCY, 32, total stall cycles for a mult/div held in ID (legal range >=2)
CNT_W, 32, width of StallCount/FlushCount
REG_W, 5, register-specifier width

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  synchronous, active-high reset
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rt  in  REG_W  load destination register
IFID_Rs  in  REG_W  ID-stage source register rs
IFID_Rt  in  REG_W  ID-stage source register rt
IFID_UsesRt  in  1  ID instruction reads rt
Branch_Taken  in  1  branch in ID resolved taken
Jump  in  1  jump in ID
MDU_Start  in  1  ID instruction is mult/div
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID buffer load enable
IFFlush  out  1  IF/ID buffer clears to 0 (NOP) at next edge
IDEX_Bubble  out  1  ID/EX control zeroed at next edge
MDU_Busy  out  1  high in MDU_WAIT
StallCount  out  CNT_W  saturating count of stall cycles
FlushCount  out  CNT_W  saturating count of flush cycles

Behaviour:
- Signal classes:
  - The four control outputs are combinational (Mealy) from state + inputs.
  - State, the counter, the release flag and the statistics are registered.
- Reset:
  - While Rst=1 the outputs are PCWrite=0, IFIDWrite=0, IFFlush=1, IDEX_Bubble=1, MDU_Busy=0.
  - At the edge with Rst=1: state<=RUN, mdu_cnt<=0, release<=0, StallCount<=0, FlushCount<=0.
  - Reset in MDU_WAIT aborts the wait with no release cycle.
- Load-use detection:
  - loaduse = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
  - $zero is never a hazard.
- States: RUN, MDU_WAIT.
- RUN priority, evaluated each cycle:
  1. loaduse: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFFlush=0; stay in RUN. Exactly 1 stall cycle per load. Branch_Taken/Jump are ignored this cycle because operands are not yet valid.
  2. Branch_Taken|Jump: PCWrite=1, IFIDWrite=1, IFFlush=1, IDEX_Bubble=0. Exactly 1 flush cycle.
  3. MDU_Start & !release: stall outputs as in case 1; load mdu_cnt=MDU_LATENCY-2; go to MDU_WAIT.
  4. Otherwise: PCWrite=1, IFIDWrite=1, IFFlush=0, IDEX_Bubble=0.
- MDU_WAIT:
  - Outputs: stall outputs, MDU_Busy=1; Branch_Taken, Jump and loaduse are ignored.
  - If mdu_cnt!=0: decrement and stay in MDU_WAIT.
  - If mdu_cnt==0: go to RUN with release<=1.
  - Total stall = MDU_LATENCY cycles, counting the detecting RUN cycle.
- release flag:
  - Masks MDU_Start for exactly one RUN cycle, so the held mult/div advances; cleared at the following edge.
  - loaduse and flush still take priority during the release cycle.
- Statistics:
  - StallCount +1 on every cycle with IDEX_Bubble=1 outside reset.
  - FlushCount +1 on every cycle with IFFlush=1 outside reset.
  - Both saturate at all-ones and never wrap.
- Invariants:
  - IFFlush and IDEX_Bubble are never both 1 outside reset.
  - PCWrite==IFIDWrite always.

Decomposition:
- Shared package holds:
  - state encoding ST_RUN=1'b0, ST_MDU_WAIT=1'b1
  - REG_ZERO constant
  - default MDU_LATENCY
- One natural sub-module: hazard_loaduse_detect, a pure comparator producing loaduse; reused by the forwarding unit's bench.

Test Plan:
- Reset mid-MDU: Rst=1 at wait cycle 5 -> outputs forced to reset values; next cycle with Rst=0, RUN and StallCount=0; MDU_Start high then stalls a fresh 32 cycles with no release.
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; next cycle (MemRead=0) normal; StallCount=1.
- $zero and unused rt:
  - IDEX_Rt=0=IFID_Rs -> no stall.
  - IDEX_Rt=9=IFID_Rt with IFID_UsesRt=0 -> no stall.
- Branch vs load-use: Branch_Taken=1 with loaduse=1 -> stall only, IFFlush=0; next cycle Branch_Taken=1 alone -> IFFlush=1, PCWrite=1, FlushCount=1.
- MDU: MDU_Start held high, MDU_LATENCY=32 -> IDEX_Bubble=1 for exactly 32 consecutive cycles, MDU_Busy high for the last 31, then one advance cycle (PCWrite=1); StallCount=32.
- Saturation: CNT_W=4, 20 load-use stalls -> StallCount=15 and holds.
